// File: rtl/des_iter_ctrl_if.sv
// Block-level handshake between the host-side crypto wrapper and the
// iterative DES controller.
//   in_valid/in_ready   : request handshake; in_decrypt, in_key, in_data ride along
//   out_valid/out_ready : result handshake; out_data carries the result block
//   busy                : a block is being processed or its result is pending
// All 64-bit fields use bit 63 = DES bit 1.
interface des_iter_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [63:0] in_key;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    // Host / wrapper side.
    modport master (
        output in_valid, in_decrypt, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, in_decrypt, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one shared round datapath (E-expansion, key XOR,
// S-boxes, P-permutation) stepped through 16 rounds per 64-bit block, with
// the key schedule kept in the C/D registers for both directions.
//   sbox          : the eight DES S-boxes, data_in[47:42] -> S1 -> data_out[31:28]
//   des_iter_ctrl : ports clk, rst_n (async, active low) and bus (slave modport
//                   of des_iter_ctrl_if) carrying both block handshakes.

module sbox (
    input  logic [47:0] data_in,
    output logic [31:0] data_out
);
    // Each entry holds one S-box as 64 nibbles, row-major (row 0 col 0 first).
    localparam logic [255:0] S_T [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    always_comb begin
        logic [5:0] six;
        logic [5:0] idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        data_out = '0;
        six      = '0;
        idx      = '0;
        for (int s = 0; s < 8; s++) begin
            six = 6'(data_in >> (42 - 6 * s));
            // Row comes from the outer bits, column from the inner four.
            idx = {six[5], six[0], six[4:1]};
            data_out = {data_out[27:0], 4'(S_T[s] >> (252 - 4 * int'(idx)))};
        end
    end
endmodule

module des_iter_ctrl (
    input logic            clk,
    input logic            rst_n,
    des_iter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

    // Permutation tables in DES numbering (1 = MSB of the source word).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - FP_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], x[5'(32 - E_T[i])]};
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y = '0;
        for (int i = 0; i < 32; i++) y = {y[30:0], x[5'(32 - P_T[i])]};
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y = '0;
        for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
        return y;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_e      state_q;
    logic [3:0]  rnd_q;
    logic        mode_q;      // 1 = decrypt
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [63:0] out_data_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic        enc_two, dec_two;
    logic [27:0] c_use, d_use, c_next, d_next;
    logic [47:0] round_key, sbox_in;
    logic [31:0] sbox_out, r_new;

    // Rotation amounts: encrypt rotates left before the key is taken; decrypt
    // takes the key first (PC-1 output already equals K16) and then walks the
    // schedule backwards with right rotations. Rounds with a single-bit step
    // are the exceptions; decrypt round 15 has no successor, so its value is moot.
    assign enc_two = !(rnd_q inside {4'd0, 4'd1, 4'd8, 4'd15});
    assign dec_two = !(rnd_q inside {4'd0, 4'd7, 4'd14, 4'd15});

    always_comb begin
        c_use  = c_q;
        d_use  = d_q;
        c_next = c_q;
        d_next = d_q;
        if (mode_q) begin
            c_next = rotr(c_q, dec_two);
            d_next = rotr(d_q, dec_two);
        end else begin
            c_use  = rotl(c_q, enc_two);
            d_use  = rotl(d_q, enc_two);
            c_next = c_use;
            d_next = d_use;
        end
    end

    assign round_key = pc2_perm({c_use, d_use});
    assign sbox_in   = e_perm(r_q) ^ round_key;
    assign r_new     = l_q ^ p_perm(sbox_out);

    sbox u_sbox (
        .data_in  (sbox_in),
        .data_out (sbox_out)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            mode_q      <= 1'b0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        {l_q, r_q}  <= ip_perm(bus.in_data);
                        {c_q, d_q}  <= pc1_perm(bus.in_key);
                        mode_q      <= bus.in_decrypt;
                        rnd_q       <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    l_q   <= r_q;
                    r_q   <= r_new;
                    c_q   <= c_next;
                    d_q   <= d_next;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'd15) begin
                        // Final swap happens only on the way out: {R16, L16}.
                        out_data_q  <= fp_perm({r_new, r_q});
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl: known-answer vectors, backpressure,
// reset mid-round, and randomized blocks against a whole-block DES model.
module tb_des_iter_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    des_iter_ctrl_if bus ();

    des_iter_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

    // Reference DES tables (DES numbering, 1 = MSB).
    localparam int IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };
    localparam int P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    // Textbook DES: build all 16 subkeys up front, run the Feistel network,
    // undo the swap, then apply the inverse of IP.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                            input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] t, y;
        logic [31:0] l, r, so, f, tmp;
        logic [47:0] ex;
        logic [5:0]  six;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - PC1[i])]};
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            c = 28'((c << SHIFTS[n]) | (c >> (28 - SHIFTS[n])));
            d = 28'((d << SHIFTS[n]) | (d >> (28 - SHIFTS[n])));
            cd = {c, d};
            ks[n] = '0;
            for (int i = 0; i < 48; i++) ks[n] = {ks[n][46:0], cd[6'(56 - PC2[i])]};
        end
        t = '0;
        for (int i = 0; i < 64; i++) t = {t[62:0], blk[6'(64 - IP[i])]};
        l = t[63:32];
        r = t[31:0];
        for (int n = 0; n < 16; n++) begin
            ex = '0;
            for (int i = 0; i < 48; i++) ex = {ex[46:0], r[5'(32 - E[i])]};
            ex = ex ^ (dec ? ks[15 - n] : ks[n]);
            so = '0;
            for (int s = 0; s < 8; s++) begin
                six = 6'(ex >> (42 - 6 * s));
                so = {so[27:0], 4'(SB[s] >> (252 - 4 * (32 * int'(six[5]) + 16 * int'(six[0])
                                                        + int'(six[4:1]))))};
            end
            f = '0;
            for (int i = 0; i < 32; i++) f = {f[30:0], so[5'(32 - P[i])]};
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        t = {r, l};
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(64 - IP[i])] = t[6'(63 - i)];
        return y;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request after 'gap' idle cycles; returns at the negedge after accept.
    task automatic send(input logic [63:0] key, input logic [63:0] data, input logic dec,
                        input int gap);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_key     = key;
        bus.in_data    = data;
        bus.in_decrypt = dec;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {63'b0, bus.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Inputs are not required to stay stable after accept.
        bus.in_valid   = 1'b0;
        bus.in_key     = {$urandom, $urandom};
        bus.in_data    = {$urandom, $urandom};
        bus.in_decrypt = 1'($urandom_range(0, 1));
        bus.out_ready  = 1'($urandom_range(0, 1));
    endtask

    // Wait for the result, check latency, then complete the output handshake.
    task automatic collect(output logic [63:0] res);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        check("latency", 64'(lat), 64'd16);
        res = bus.out_data;
        if (!bus.out_ready) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("out_hold", bus.out_data, res);
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid_drop", {63'b0, bus.out_valid}, 64'd0);
        check("in_ready_back", {63'b0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                             input int gap, output logic [63:0] res);
        send(key, data, dec, gap);
        collect(res);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, back, key, data, held;
        logic        dec;
        int          lat;

        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.in_key     = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;

        #2 rst_n = 1'b0;
        #10;
        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer and zero vectors.
        run_block(KAT_KEY, KAT_PT, 1'b0, 0, res);
        check("kat_enc", res, KAT_CT);
        run_block(KAT_KEY, KAT_CT, 1'b1, 1, res);
        check("kat_dec", res, KAT_PT);
        run_block(64'd0, 64'd0, 1'b0, 0, res);
        check("zero_enc", res, ZERO_CT);
        run_block(64'd0, ZERO_CT, 1'b1, 2, res);
        check("zero_dec", res, 64'd0);

        // Backpressure: result must hold while new requests are ignored.
        send(KAT_KEY, KAT_PT, 1'b0, 0);
        bus.out_ready = 1'b0;
        check("bp_busy", {63'b0, bus.busy}, 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        check("bp_latency", 64'(lat), 64'd16);
        held = bus.out_data;
        check("bp_data", held, KAT_CT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_data    = {$urandom, $urandom};
            bus.in_key     = {$urandom, $urandom};
            bus.in_decrypt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("bp_hold_data", bus.out_data, KAT_CT);
            check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
            check("bp_out_valid", {63'b0, bus.out_valid}, 64'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {63'b0, bus.out_valid}, 64'd0);
        check("bp_release_ready", {63'b0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_no_second_accept", {63'b0, bus.busy}, 64'd0);

        // Reset in the middle of round 7.
        send(KAT_KEY, KAT_PT, 1'b0, 0);
        bus.out_ready = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("midrst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        check("midrst_busy", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(KAT_KEY, KAT_PT, 1'b0, 1, res);
        check("midrst_kat_enc", res, KAT_CT);

        // Randomized blocks: each result against the model, then the reverse
        // direction on the DUT must restore the original data.
        for (int i = 0; i < 500; i++) begin
            key  = {$urandom, $urandom};
            data = {$urandom, $urandom};
            dec  = 1'($urandom_range(0, 1));
            run_block(key, data, dec, $urandom_range(0, 4), res);
            check("rand_model", res, des_ref(key, data, dec));
            run_block(key, res, !dec, $urandom_range(0, 4), back);
            check("rand_roundtrip", back, data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
